// File: rtl/pattern_phase_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_phase_mux : programmable pattern slots, LSB-first word serialiser
// Revision 1.0
// ---------------------------------------------------------------------------
module pattern_phase_mux #(
  parameter int                      WIDTH     = 10,
  parameter int                      NCH       = 4,
  parameter int                      SELW      = 2,
  parameter logic [NCH*WIDTH-1:0]    INIT_PAT  = {10'b0101010101, 10'b1010101010,
                                                  10'b1111000011, 10'b1001011010},
  parameter int                      RESET_SEL = 0
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             ien,
  input  logic             iwr_en,
  input  logic [SELW-1:0]  iwr_addr,
  input  logic [WIDTH-1:0] iwr_data,
  input  logic [SELW-1:0]  isel,
  input  logic             isel_vld,
  output logic             osel_rdy,
  output logic [SELW-1:0]  oactive_sel,
  output logic [WIDTH-1:0] mux_out,
  output logic             oser,
  output logic             oword_start
);

  localparam int             c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_slot [NCH];
  logic [SELW-1:0]     r_active;
  logic                r_pend_vld;
  logic [SELW-1:0]     r_pend_sel;
  logic                r_sel_rdy;
  logic [WIDTH-1:0]    r_mux;
  logic                r_ser;
  logic                r_word_start;
  logic [c_cnt_w-1:0]  r_cnt;

  logic                w_wr_ok;
  logic                w_sel_ok;
  logic                w_accept;
  logic                w_take_sel;
  logic [SELW-1:0]     w_next_sel;
  logic [WIDTH-1:0]    w_load_word;
  logic [c_cnt_w-1:0]  w_cnt_nxt;

  // Out-of-range slot numbers only exist when NCH is not a power of two.
  generate
    if ((1 << SELW) > NCH) begin : g_range_chk
      assign w_wr_ok  = (int'(iwr_addr) < NCH);
      assign w_sel_ok = (int'(isel) < NCH);
    end else begin : g_full_range
      assign w_wr_ok  = 1'b1;
      assign w_sel_ok = 1'b1;
    end
  endgenerate

  assign w_accept   = isel_vld & r_sel_rdy;
  assign w_take_sel = w_accept & w_sel_ok;

  // Pending request wins; in IDLE a fresh request applies without waiting.
  assign w_next_sel = r_pend_vld ? r_pend_sel :
                      ((r_state == ST_IDLE) && w_take_sel) ? isel : r_active;
  assign w_load_word = r_slot[w_next_sel];
  assign w_cnt_nxt   = r_cnt + 1'b1;

  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int k = 0; k < NCH; k++) begin
        r_slot[k] <= INIT_PAT[k*WIDTH +: WIDTH];
      end
      r_state      <= ST_IDLE;
      r_active     <= SELW'(RESET_SEL);
      r_pend_vld   <= 1'b0;
      r_pend_sel   <= '0;
      r_sel_rdy    <= 1'b1;
      r_mux        <= '0;
      r_ser        <= 1'b0;
      r_word_start <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (iwr_en && w_wr_ok) begin
        r_slot[iwr_addr] <= iwr_data;
      end
      case (r_state)
        ST_IDLE: begin
          r_active   <= w_next_sel;
          r_pend_vld <= 1'b0;
          r_sel_rdy  <= 1'b1;
          r_cnt      <= '0;
          if (ien) begin
            r_state      <= ST_RUN;
            r_mux        <= w_load_word;
            r_ser        <= w_load_word[0];
            r_word_start <= 1'b1;
          end else begin
            r_ser        <= 1'b0;
            r_word_start <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!ien) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_ser        <= 1'b0;
            r_word_start <= 1'b0;
          end else if (r_cnt == c_last) begin
            r_active     <= w_next_sel;
            r_pend_vld   <= 1'b0;
            r_sel_rdy    <= 1'b1;
            r_mux        <= w_load_word;
            r_ser        <= w_load_word[0];
            r_word_start <= 1'b1;
            r_cnt        <= '0;
          end else begin
            r_cnt        <= w_cnt_nxt;
            r_ser        <= r_mux[w_cnt_nxt];
            r_word_start <= 1'b0;
          end
          // A request taken on a reload edge waits for the following boundary.
          if (w_take_sel) begin
            r_pend_vld <= 1'b1;
            r_pend_sel <= isel;
            r_sel_rdy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign osel_rdy    = r_sel_rdy;
  assign oactive_sel = r_active;
  assign mux_out     = r_mux;
  assign oser        = r_ser;
  assign oword_start = r_word_start;

endmodule
`default_nettype wire

// File: tb/tb_pattern_phase_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pattern_phase_mux : scoreboard bench for pattern_phase_mux
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pattern_phase_mux;

  logic       iclk = 1'b0;
  logic       irst;
  logic       ien;
  logic       iwr_en;
  logic [1:0] iwr_addr;
  logic [9:0] iwr_data;
  logic [1:0] isel;
  logic       isel_vld;
  logic       osel_rdy;
  logic [1:0] oactive_sel;
  logic [9:0] mux_out;
  logic       oser;
  logic       oword_start;

  logic       ien2;
  logic [1:0] isel2;
  logic       isel_vld2;
  logic       osel_rdy2;
  logic [1:0] oactive_sel2;
  logic [9:0] mux_out2;
  logic       oser2;
  logic       oword_start2;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  typedef struct {
    logic [1:0] sel;
    logic [9:0] word;
    bit         full;
  } exp_t;

  exp_t sb[$];

  always #5 iclk = ~iclk;

  pattern_phase_mux u_dut (
    .iclk       (iclk),
    .irst       (irst),
    .ien        (ien),
    .iwr_en     (iwr_en),
    .iwr_addr   (iwr_addr),
    .iwr_data   (iwr_data),
    .isel       (isel),
    .isel_vld   (isel_vld),
    .osel_rdy   (osel_rdy),
    .oactive_sel(oactive_sel),
    .mux_out    (mux_out),
    .oser       (oser),
    .oword_start(oword_start)
  );

  pattern_phase_mux #(
    .WIDTH   (10),
    .NCH     (3),
    .SELW    (2),
    .INIT_PAT({10'b1010101010, 10'b1111000011, 10'b1001011010})
  ) u_dut3 (
    .iclk       (iclk),
    .irst       (irst),
    .ien        (ien2),
    .iwr_en     (1'b0),
    .iwr_addr   (2'd0),
    .iwr_data   (10'd0),
    .isel       (isel2),
    .isel_vld   (isel_vld2),
    .osel_rdy   (osel_rdy2),
    .oactive_sel(oactive_sel2),
    .mux_out    (mux_out2),
    .oser       (oser2),
    .oword_start(oword_start2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
    ecnt++;
  endtask

  task automatic goto_edge(input int n);
    while (ecnt < n) tick();
  endtask

  task automatic push(input logic [1:0] s, input logic [9:0] w, input bit full);
    exp_t e;
    e.sel  = s;
    e.word = w;
    e.full = full;
    sb.push_back(e);
  endtask

  // Monitor: every word start pops one expected word and checks it.
  initial begin : mon
    exp_t       e;
    logic [9:0] got;
    bit         extra_ws;
    forever begin
      @(negedge iclk);
      if (oword_start) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {22'd0, mux_out}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("word_mux_out", {22'd0, mux_out}, {22'd0, e.word});
          chk("word_active_sel", {30'd0, oactive_sel}, {30'd0, e.sel});
          if (e.full) begin
            got      = '0;
            extra_ws = 1'b0;
            got[0]   = oser;
            for (int i = 1; i < 10; i++) begin
              @(negedge iclk);
              got[i] = oser;
              if (oword_start) extra_ws = 1'b1;
            end
            chk("word_serial", {22'd0, got}, {22'd0, e.word});
            chk("word_start_gap", {31'd0, extra_ws}, 32'd0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    irst = 1'b1; ien = 1'b0; iwr_en = 1'b0; iwr_addr = '0; iwr_data = '0;
    isel = '0; isel_vld = 1'b0;
    ien2 = 1'b0; isel2 = '0; isel_vld2 = 1'b0;
    tick(); tick();
    chk("rst_sel_rdy", {31'd0, osel_rdy}, 32'd1);
    chk("rst_active_sel", {30'd0, oactive_sel}, 32'd0);
    chk("rst_mux_out", {22'd0, mux_out}, 32'd0);
    chk("rst_oser", {31'd0, oser}, 32'd0);
    chk("rst_word_start", {31'd0, oword_start}, 32'd0);
    irst = 1'b0;
    tick();

    // Three-slot instance: slot number 3 does not exist.
    isel2 = 2'd3; isel_vld2 = 1'b1;
    tick();
    chk("n3_idle_bad_sel_rdy", {31'd0, osel_rdy2}, 32'd1);
    chk("n3_idle_bad_sel_active", {30'd0, oactive_sel2}, 32'd0);
    isel2 = 2'd2;
    tick();
    isel_vld2 = 1'b0;
    chk("n3_idle_sel2_active", {30'd0, oactive_sel2}, 32'd2);
    ien2 = 1'b1;
    tick(); tick(); tick();
    isel2 = 2'd3; isel_vld2 = 1'b1;
    tick();
    isel_vld2 = 1'b0;
    chk("n3_run_bad_sel_rdy", {31'd0, osel_rdy2}, 32'd1);
    repeat (10) tick();
    chk("n3_run_bad_sel_active", {30'd0, oactive_sel2}, 32'd2);
    chk("n3_run_word", {22'd0, mux_out2}, 32'h2AA);
    ien2 = 1'b0;

    // Main sequence; edge 0 is the first edge that samples ien=1.
    ecnt = -1;
    push(2'd0, 10'h25A, 1'b1);
    push(2'd0, 10'h25A, 1'b1);
    ien = 1'b1;
    goto_edge(0);

    goto_edge(14);
    isel = 2'd2; isel_vld = 1'b1;
    goto_edge(15);
    isel_vld = 1'b0;
    chk("sel_rdy_after_accept", {31'd0, osel_rdy}, 32'd0);
    chk("active_holds_midword", {30'd0, oactive_sel}, 32'd0);
    push(2'd2, 10'h2AA, 1'b1);
    goto_edge(20);
    chk("sel_rdy_after_reload", {31'd0, osel_rdy}, 32'd1);

    goto_edge(22);
    isel = 2'd0; isel_vld = 1'b1;
    goto_edge(23);
    isel_vld = 1'b0;
    push(2'd0, 10'h25A, 1'b1);
    goto_edge(33);
    iwr_en = 1'b1; iwr_addr = 2'd0; iwr_data = 10'h3FF;
    goto_edge(34);
    iwr_en = 1'b0;
    push(2'd0, 10'h3FF, 1'b1);

    goto_edge(49);
    isel = 2'd3; isel_vld = 1'b1;
    goto_edge(50);
    isel_vld = 1'b0;
    chk("reload_edge_req_rdy", {31'd0, osel_rdy}, 32'd0);
    push(2'd0, 10'h3FF, 1'b1);
    push(2'd3, 10'h155, 1'b1);

    goto_edge(69);
    iwr_en = 1'b1; iwr_addr = 2'd3; iwr_data = 10'h0F0;
    goto_edge(70);
    iwr_en = 1'b0;
    push(2'd3, 10'h155, 1'b1);
    push(2'd3, 10'h0F0, 1'b0);

    goto_edge(81);
    isel = 2'd1; isel_vld = 1'b1;
    goto_edge(82);
    isel_vld = 1'b0;
    goto_edge(85);
    ien = 1'b0;
    goto_edge(86);
    chk("abort_oser", {31'd0, oser}, 32'd0);
    chk("abort_word_start", {31'd0, oword_start}, 32'd0);
    chk("abort_active_kept", {30'd0, oactive_sel}, 32'd3);
    goto_edge(87);
    chk("idle_pending_applied", {30'd0, oactive_sel}, 32'd1);
    chk("idle_pending_rdy", {31'd0, osel_rdy}, 32'd1);
    chk("idle_mux_holds", {22'd0, mux_out}, 32'h0F0);
    push(2'd1, 10'h3C3, 1'b1);
    push(2'd1, 10'h3C3, 1'b0);
    goto_edge(88);
    ien = 1'b1;

    goto_edge(100);
    iwr_en = 1'b1; iwr_addr = 2'd1; iwr_data = 10'h001;
    goto_edge(101);
    iwr_en = 1'b0;
    goto_edge(103);
    irst = 1'b1;
    goto_edge(104);
    irst = 1'b0; ien = 1'b0;
    chk("midrst_sel_rdy", {31'd0, osel_rdy}, 32'd1);
    chk("midrst_active_sel", {30'd0, oactive_sel}, 32'd0);
    chk("midrst_mux_out", {22'd0, mux_out}, 32'd0);
    chk("midrst_oser", {31'd0, oser}, 32'd0);
    chk("midrst_word_start", {31'd0, oword_start}, 32'd0);

    goto_edge(105);
    isel = 2'd1; isel_vld = 1'b1;
    goto_edge(106);
    isel_vld = 1'b0;
    chk("idle_sel_immediate", {30'd0, oactive_sel}, 32'd1);
    chk("idle_sel_rdy", {31'd0, osel_rdy}, 32'd1);
    push(2'd1, 10'h3C3, 1'b1);
    ien = 1'b1;
    goto_edge(116);
    ien = 1'b0;
    goto_edge(118);
    isel = 2'd0; isel_vld = 1'b1;
    goto_edge(119);
    isel_vld = 1'b0;
    push(2'd0, 10'h25A, 1'b1);
    ien = 1'b1;
    goto_edge(129);
    ien = 1'b0;
    goto_edge(133);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pattern_phase_mux.md
Name: pattern_phase_mux

Overview:
- Parametrised successor to the fixed 4-pattern selector.
- Holds NCH programmable WIDTH-bit pattern slots and selects one via a ready/valid select handshake.
- Serialises the selected word LSB-first. Select changes take effect only on word boundaries, so output words never tear.
- Sits between the control/register interface and the phase-alignment/training transmitter datapath.

Parameters:
- WIDTH, 10, bits per pattern word (>=2).
- NCH, 4, number of pattern slots (>=2).
- SELW, 2, select/address width; must equal clog2(NCH).
- INIT_PAT, {10'b0101010101,10'b1010101010,10'b1111000011,10'b1001011010}, NCH*WIDTH packed reset contents; slot k = bits [k*WIDTH +: WIDTH].
- RESET_SEL, 0, active slot after reset.

Ports:
- iclk  in  1  clock.
- irst  in  1  reset; synchronous, active-high.
- ien  in  1  serializer enable.
- iwr_en  in  1  pattern slot write strobe.
- iwr_addr  in  SELW  slot written.
- iwr_data  in  WIDTH  pattern write data.
- isel  in  SELW  requested slot.
- isel_vld  in  1  select request valid.
- osel_rdy  out  1  select request can be accepted.
- oactive_sel  out  SELW  slot currently being serialised.
- mux_out  out  WIDTH  registered word currently being serialised.
- oser  out  1  serial bit.
- oword_start  out  1  high on the cycle oser carries bit 0 of a word.

Behaviour:
- Reset values:
  - pattern slots = INIT_PAT
  - oactive_sel = RESET_SEL; pending flag = 0
  - osel_rdy = 1
  - mux_out, oser, oword_start = 0
  - state = IDLE; bit counter = 0
- Pattern writes: when iwr_en=1, slot[iwr_addr] <= iwr_data at the clock edge. An iwr_addr >= NCH is ignored. Writes are accepted in any state.
- Select handshake: a request is accepted when isel_vld and osel_rdy are both 1 at an edge. The accepted value goes to the pending register and osel_rdy drops to 0 on the next cycle. An isel >= NCH is accepted but discarded: no pending is set and osel_rdy stays 1.
- State IDLE (ien=0):
  - oser = 0, oword_start = 0, mux_out holds its last value.
  - An accepted select applies immediately: oactive_sel updates on the next edge and osel_rdy stays 1.
- IDLE -> RUN: when ien=1 at edge t, at t+1:
  - mux_out = slot[oactive_sel], where oactive_sel includes any pending request applied at edge t
  - oser = mux_out[0], oword_start = 1, counter = 0
- State RUN:
  - Each cycle, counter increments and oser = mux_out[counter].
  - When counter = WIDTH-1, the next edge reloads: if pending, oactive_sel <= pending, pending clears, osel_rdy <= 1. Then mux_out <= slot[new oactive_sel], counter <= 0, oword_start = 1.
  - Words are back-to-back with no gap bits.
- RUN -> IDLE: ien=0 at any edge aborts at that edge. Counter <= 0, oser <= 0, oword_start <= 0. A pending select is retained and applies on the next cycle (IDLE rule).
- Write to the active slot during RUN: the current word is unaffected because mux_out is a snapshot. The new data appears at the next reload.
- Write and reload of the same slot on the same edge: the reload takes the pre-write value; the new value appears one word later.
- Select accepted on the reload edge itself (osel_rdy=1, counter=WIDTH-1): it does not affect that reload; it becomes pending for the following boundary.
- irst mid-word: it takes priority over all other inputs at that edge. All state returns to reset values, including pattern slots. The partial word is dropped.
- Latency:
  - select accept -> oactive_sel change: <= WIDTH cycles in RUN, 1 cycle in IDLE.
  - ien rise -> first bit: 1 cycle.

Test Plan:
- Reset, then ien=1 with defaults, WIDTH=10 -> oword_start every 10 cycles. oser stream = 0,1,0,1,1,0,1,0,0,1 repeating (slot0 10'b1001011010, LSB first). mux_out = 10'h25A.
- In RUN, isel=2 with isel_vld pulsed mid-word (counter=4) -> osel_rdy low on the next cycle. The current word completes as slot0. The next word is 10'h2AA with oactive_sel=2, and osel_rdy returns high on that reload edge.
- Write slot0 = 10'h3FF at counter=3 while slot0 is active -> the current word finishes as 10'h25A; the next word is 10'h3FF (all ones).
- Request on the reload edge (counter=9), isel=3 -> the next word stays at the old slot; the word after it is 10'h155.
- Drop ien at counter=5 with a pending select of 1 -> oser=0 and oword_start=0 from the next cycle. oactive_sel=1 one cycle later. Re-raising ien yields 10'h3C3 from bit 0.
- Assert irst mid-word after slot writes -> on the next cycle all outputs are at reset values and slots are back to INIT_PAT. isel=3'd? is not applicable; with NCH=3/SELW=2, isel=3 is discarded and osel_rdy stays 1.
